nibble_add_seq: RTL and testbench

NIBBLE_ADD_SEQ -- requirements
Module: nibble_add_seq

---
 rtl/nibble_add_seq.sv | 123 ++++++++++++
 tb/tb_nibble_add_seq.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/nibble_add_seq.sv
// Sequential W-bit adder that reuses one external 4-bit adder, one nibble per cycle.
// Optional subtract mode is enabled by defining NIBBLE_ADD_SEQ_SUB_EN.
module nibble_add_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_valid,
  output logic                   start_ready,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
`ifdef NIBBLE_ADD_SEQ_SUB_EN
  input  logic                   op,
`endif
  input  logic                   cin,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_sum,
  input  logic                   add_cout,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
  output logic                   ovf,
  output logic                   busy
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;

  logic [W-1:0]  a_reg, b_reg, b_eff, acc, acc_nx, sum_q;
  logic [CW-1:0] cnt;
  logic          carry, carry_init, cout_q, ovf_q;
  logic          accept, last;

`ifdef NIBBLE_ADD_SEQ_SUB_EN
  logic op_reg;
  assign b_eff      = op_reg ? ~b_reg : b_reg;
  assign carry_init = op ? 1'b1 : cin;
`else
  assign b_eff      = b_reg;
  assign carry_init = cin;
`endif

  assign start_ready  = (state == IDLE);
  assign result_valid = (state == DONE);
  assign busy         = (state != IDLE);
  assign accept       = start_valid && start_ready;
  assign last         = (state == RUN) && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start_valid) state_nx = RUN;
      RUN:     if (cnt == LAST) state_nx = DONE;
      DONE:    if (result_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = a_reg[4*cnt +: 4];
      add_b   = b_eff[4*cnt +: 4];
      add_cin = carry;
    end
    acc_nx             = acc;
    acc_nx[4*cnt +: 4] = add_sum;
  end

  // Partial sums build up in acc; sum/cout/ovf are only updated on the final
  // nibble so the previous result stays visible through IDLE and RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg  <= '0;
      b_reg  <= '0;
      acc    <= '0;
      sum_q  <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
      op_reg <= 1'b0;
`endif
    end else if (accept) begin
      a_reg <= a;
      b_reg <= b;
      cnt   <= '0;
      carry <= carry_init;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
      op_reg <= op;
`endif
    end else if (state == RUN) begin
      acc   <= acc_nx;
      carry <= add_cout;
      cnt   <= last ? '0 : cnt + 1'b1;
      if (last) begin
        sum_q  <= acc_nx;
        cout_q <= add_cout;
        ovf_q  <= (a_reg[W-1] == b_eff[W-1]) && (acc_nx[W-1] != a_reg[W-1]);
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_add_seq.sv
// Self-checking bench for nibble_add_seq (NIBBLES=4) with a behavioural 4-bit adder.
// Define NIBBLE_ADD_SEQ_SUB_EN to also exercise subtract mode.
module tb_nibble_add_seq;
  localparam int N = 4;
  localparam int W = 16;

  logic         clk = 1'b0, rst = 1'b1;
  logic         start_valid = 1'b0, start_ready;
  logic [W-1:0] a = '0, b = '0, sum;
  logic         cin = 1'b0;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
  logic         op = 1'b0;
`endif
  logic [3:0]   add_a, add_b, add_sum;
  logic         add_cin, add_cout;
  logic         result_valid, result_ready = 1'b0;
  logic         cout, ovf, busy;

  nibble_add_seq #(.NIBBLES(N)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .a(a), .b(b),
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    .op(op),
`endif
    .cin(cin), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout), .result_valid(result_valid),
    .result_ready(result_ready), .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic txn(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                     input logic top, input int hold);
    logic [16:0]  full;
    logic [W-1:0] be, seq;
    exp_t         e;
    int           n;
    be   = top ? ~tb_ : tb_;
    full = {1'b0, ta} + {1'b0, be} + (top ? 17'd1 : {16'd0, tc});
    e.s  = full[15:0];
    e.c  = full[16];
    e.v  = (ta[15] == be[15]) && (full[15] != ta[15]);
    @(negedge clk);
    chk("start_ready_idle", start_ready, 1);
    a = ta; b = tb_; cin = tc;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    op = top;
`endif
    start_valid = 1'b1;
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    a = ~ta; b = ~tb_; cin = ~tc;
    n = 0; seq = '0;
    while (!result_valid && n < 20) begin
      seq = {add_a, seq[W-1:4]};
      @(negedge clk);
      n++;
    end
    chk("latency", n, N);
    chk("add_a_seq", seq, ta);
    e = q.pop_front();
    chk("sum", sum, e.s);
    chk("cout", cout, e.c);
    chk("ovf", ovf, e.v);
    chk("busy_done", busy, 1);
    chk("start_ready_done", start_ready, 0);
    if (hold > 0) start_valid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", result_valid, 1);
      chk("hold_sum", sum, e.s);
      chk("hold_cout", cout, e.c);
      chk("hold_start_ready", start_ready, 0);
    end
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    start_valid  = 1'b0;
    chk("exit_valid", result_valid, 0);
    chk("exit_busy", busy, 0);
    chk("exit_start_ready", start_ready, 1);
    chk("idle_sum_kept", sum, e.s);
  endtask

  initial begin
    int rv_seen;
    @(negedge clk);
    chk("rst_start_ready", start_ready, 1);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout_ovf", {cout, ovf}, 0);
    chk("rst_add", {add_a, add_b, add_cin}, 0);
    rst = 1'b0;

    txn(16'h1234, 16'h4321, 1'b0, 1'b0, 0);
    txn(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    txn(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
    txn(16'h8000, 16'h8000, 1'b1, 1'b0, 5);
    txn(16'h0F0F, 16'hF0F1, 1'b0, 1'b0, 0);

    // abort after two RUN cycles
    @(negedge clk);
    a = 16'hAAAA; b = 16'h5555; cin = 1'b0; start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_start_ready", start_ready, 1);
    chk("abort_valid", result_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_sum", sum, 0);
    chk("abort_cout_ovf", {cout, ovf}, 0);
    chk("abort_add", {add_a, add_b, add_cin}, 0);
    @(negedge clk);
    rst = 1'b0;
    rv_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (result_valid) rv_seen++;
    end
    chk("abort_no_valid", rv_seen, 0);
    txn(16'h0001, 16'h0001, 1'b1, 1'b0, 0);

`ifdef NIBBLE_ADD_SEQ_SUB_EN
    txn(16'h0005, 16'h0007, 1'b1, 1'b1, 0);
    txn(16'h0007, 16'h0005, 1'b0, 1'b1, 2);
    txn(16'h8000, 16'h0001, 1'b0, 1'b1, 0);
`endif

    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        for (int c = 0; c < 2; c++)
          txn(W'(i), W'(j), c[0], 1'b0, 0);

    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
